// File: rtl/riscv_id_opgen.sv
// Decode / operand-generation stage: builds registered opA/opB for the ALU,
// forwards from EX/MEM/WB and inserts bubbles on RAW and load-use hazards.
module riscv_id_fwd #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_rfv,
  input  logic [XLEN-1:0] i_alu_r,
  input  logic            i_alu_bubble,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_ex_load,
  input  logic [XLEN-1:0] i_mem_r,
  input  logic            i_mem_bubble,
  input  logic [4:0]      i_mem_rd,
  input  logic [XLEN-1:0] i_wb_r,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_dst,
  output logic [XLEN-1:0] o_val
);
  // A load's alu_r is an address, never the loaded data.
  always_comb begin
    o_val = i_rfv;
    if (i_rs == 5'd0)                                       o_val = '0;
    else if (!i_alu_bubble && i_ex_rd == i_rs && !i_ex_load) o_val = i_alu_r;
    else if (!i_mem_bubble && i_mem_rd == i_rs)             o_val = i_mem_r;
    else if (i_wb_we && i_wb_dst == i_rs)                   o_val = i_wb_r;
  end
endmodule

module riscv_id_opgen #(
  parameter int              XLEN    = 64,
  parameter int              ILEN    = 64,
  parameter logic [XLEN-1:0] PC_INIT = XLEN'('h200)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic            pipe_flush,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_instr,
  input  logic            if_bubble,
  output logic            id_stall,
  output logic [4:0]      rf_src1,
  output logic [4:0]      rf_src2,
  input  logic [XLEN-1:0] rf_srcv1,
  input  logic [XLEN-1:0] rf_srcv2,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_bubble,
  input  logic [4:0]      ex_rd,
  input  logic            ex_load,
  input  logic [XLEN-1:0] mem_r,
  input  logic            mem_bubble,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] wb_r,
  input  logic            wb_we,
  input  logic [4:0]      wb_dst,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output logic            id_bubble,
  output logic [XLEN-1:0] opA,
  output logic [XLEN-1:0] opB
);
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_BR = 7'h63, OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_IMM = 7'h13;
  localparam logic [6:0] OPC_IMM32 = 7'h1b, OPC_OP = 7'h33, OPC_OP32 = 7'h3b, OPC_SYS = 7'h73;

  logic [31:0]           w_ins;
  logic [6:0]            w_opc, w_id_opc;
  logic [2:0]            w_f3;
  logic [4:0]            w_id_rd;
  logic                  w_csr_r, w_csr_i, w_use1, w_use2, w_id_wr;
  logic                  w_raw, w_lu, w_hazard;
  logic [1:0][4:0]       w_rs;
  logic [1:0][XLEN-1:0]  w_rfv, w_val;
  logic [XLEN-1:0]       w_imm_i, w_imm_s, w_imm_u, w_imm_j, w_a, w_b;

  assign w_ins   = if_instr[31:0];
  assign w_opc   = w_ins[6:0];
  assign w_f3    = w_ins[14:12];
  assign rf_src1 = w_ins[19:15];
  assign rf_src2 = w_ins[24:20];
  assign w_rs    = {rf_src2, rf_src1};
  assign w_rfv   = {rf_srcv2, rf_srcv1};

  assign w_csr_r = (w_opc == OPC_SYS) && (w_f3[2] == 1'b0) && (w_f3[1:0] != 2'b00);
  assign w_csr_i = (w_opc == OPC_SYS) && w_f3[2] && (w_f3[1:0] != 2'b00);

  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (w_opc)
      OPC_JALR, OPC_LD, OPC_IMM, OPC_IMM32: w_use1 = 1'b1;
      OPC_BR, OPC_ST, OPC_OP, OPC_OP32: begin w_use1 = 1'b1; w_use2 = 1'b1; end
      OPC_SYS:                              w_use1 = w_csr_r;
      default: ;
    endcase
  end

  // Destination of the instruction sitting in the ID output register.
  assign w_id_opc = id_instr[6:0];
  assign w_id_rd  = id_instr[11:7];
  always_comb begin
    w_id_wr = 1'b0;
    case (w_id_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LD,
      OPC_IMM, OPC_IMM32, OPC_OP, OPC_OP32: w_id_wr = 1'b1;
      OPC_SYS:                             w_id_wr = (id_instr[14:12] != 3'd0);
      default: ;
    endcase
  end

  assign w_raw = !id_bubble && w_id_wr && (w_id_rd != 5'd0) &&
                 ((w_use1 && w_id_rd == rf_src1) || (w_use2 && w_id_rd == rf_src2));
  assign w_lu  = !alu_bubble && ex_load &&
                 ((w_use1 && rf_src1 != 5'd0 && ex_rd == rf_src1) ||
                  (w_use2 && rf_src2 != 5'd0 && ex_rd == rf_src2));
  assign w_hazard = !if_bubble && (w_raw || w_lu);
  assign id_stall = rstn && (ex_stall || w_hazard);

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      riscv_id_fwd #(.XLEN(XLEN)) u_fwd (
        .i_rs(w_rs[g]), .i_rfv(w_rfv[g]),
        .i_alu_r(alu_r), .i_alu_bubble(alu_bubble), .i_ex_rd(ex_rd), .i_ex_load(ex_load),
        .i_mem_r(mem_r), .i_mem_bubble(mem_bubble), .i_mem_rd(mem_rd),
        .i_wb_r(wb_r), .i_wb_we(wb_we), .i_wb_dst(wb_dst),
        .o_val(w_val[g])
      );
    end
  endgenerate

  assign w_imm_i = XLEN'($signed(w_ins[31:20]));
  assign w_imm_s = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
  assign w_imm_u = XLEN'($signed({w_ins[31:12], 12'h000}));
  assign w_imm_j = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));

  always_comb begin
    w_a = '0;
    w_b = '0;
    case (w_opc)
      OPC_LUI:                      w_b = w_imm_u;
      OPC_AUIPC:           begin w_a = if_pc;    w_b = w_imm_u; end
      OPC_JAL:             begin w_a = w_val[0]; w_b = w_imm_j; end
      OPC_JALR, OPC_IMM, OPC_IMM32, OPC_LD:
                           begin w_a = w_val[0]; w_b = w_imm_i; end
      OPC_ST:              begin w_a = w_val[0]; w_b = w_imm_s; end
      OPC_OP, OPC_OP32, OPC_BR:
                           begin w_a = w_val[0]; w_b = w_val[1]; end
      OPC_SYS: begin
        if (w_csr_r) w_a = w_val[0];
        if (w_csr_i) w_b = XLEN'(w_ins[19:15]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_bubble <= 1'b1;
      id_pc     <= PC_INIT;
      id_instr  <= ILEN'('h13);
      opA       <= '0;
      opB       <= '0;
    end else if (pipe_flush) begin
      id_bubble <= 1'b1;
    end else if (!ex_stall) begin
      if (w_hazard) begin
        id_bubble <= 1'b1;
      end else begin
        id_pc     <= if_pc;
        id_instr  <= if_instr;
        id_bubble <= if_bubble;
        opA       <= w_a;
        opB       <= w_b;
      end
    end
  end
endmodule

// File: tb/tb_riscv_id_opgen.sv
// Directed bench for riscv_id_opgen: decode table plus hazard/forwarding/flush sequences.
module tb_riscv_id_opgen;
  logic        clk = 1'b0;
  logic        rstn, ex_stall, pipe_flush, if_bubble, id_stall;
  logic [63:0] if_pc, if_instr, rf_srcv1, rf_srcv2, alu_r, mem_r, wb_r;
  logic [4:0]  rf_src1, rf_src2, ex_rd, mem_rd, wb_dst;
  logic        alu_bubble, ex_load, mem_bubble, wb_we;
  logic [63:0] id_pc, id_instr, opA, opB;
  logic        id_bubble;
  int          n_vec = 0, n_err = 0;

  riscv_id_opgen dut (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .pipe_flush(pipe_flush),
    .if_pc(if_pc), .if_instr(if_instr), .if_bubble(if_bubble), .id_stall(id_stall),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_srcv1(rf_srcv1), .rf_srcv2(rf_srcv2),
    .alu_r(alu_r), .alu_bubble(alu_bubble), .ex_rd(ex_rd), .ex_load(ex_load),
    .mem_r(mem_r), .mem_bubble(mem_bubble), .mem_rd(mem_rd),
    .wb_r(wb_r), .wb_we(wb_we), .wb_dst(wb_dst),
    .id_pc(id_pc), .id_instr(id_instr), .id_bubble(id_bubble), .opA(opA), .opB(opB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc, rv1, rv2, exp_a, exp_b;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] v1, input logic [63:0] v2);
    if_instr = {32'h0, ins}; if_pc = pc; rf_srcv1 = v1; rf_srcv2 = v2; if_bubble = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{32'hFFD00293, 64'h1000, 64'hDEAD, 64'h0,  64'h0,    64'hFFFF_FFFF_FFFF_FFFD}; // addi x5,x0,-3
    tbl[1]  = '{32'h12345097, 64'h1000, 64'h0,    64'h0,  64'h1000, 64'h12345000};           // auipc x1
    tbl[2]  = '{32'h80000137, 64'h1008, 64'h0,    64'h0,  64'h0,    64'hFFFF_FFFF_8000_0000}; // lui x2
    tbl[3]  = '{32'h006281B3, 64'h100C, 64'h11,   64'h22, 64'h11,   64'h22};                 // add x3,x5,x6
    tbl[4]  = '{32'hFE742C23, 64'h1010, 64'h100,  64'h55, 64'h100,  64'hFFFF_FFFF_FFFF_FFF8}; // sw x7,-8(x8)
    tbl[5]  = '{32'h3008E0F3, 64'h1014, 64'h999,  64'h0,  64'h0,    64'd17};                 // csrrsi x1,17
    tbl[6]  = '{32'h008000EF, 64'h1018, 64'h123,  64'h0,  64'h0,    64'h8};                  // jal x1,+8
    tbl[7]  = '{32'h004480E7, 64'h101C, 64'h2000, 64'h0,  64'h2000, 64'h4};                  // jalr x1,4(x9)
    tbl[8]  = '{32'h00B50063, 64'h1020, 64'hA,    64'hB,  64'hA,    64'hB};                  // beq x10,x11
    tbl[9]  = '{32'h34061073, 64'h1024, 64'h77,   64'h0,  64'h77,   64'h0};                  // csrrw x0,x12
    tbl[10] = '{32'h0000000F, 64'h1028, 64'h5,    64'h6,  64'h0,    64'h0};                  // fence
    tbl[11] = '{32'hFFF3029B, 64'h102C, 64'h40,   64'h0,  64'h40,   64'hFFFF_FFFF_FFFF_FFFF}; // addiw x5,x6,-1
    tbl[12] = '{32'h01013203, 64'h1030, 64'h8000, 64'h0,  64'h8000, 64'h10};                 // ld x4,16(x2)

    rstn = 1'b0; ex_stall = 1'b1; pipe_flush = 1'b0; if_bubble = 1'b1;
    if_pc = 64'h0; if_instr = 64'h13; rf_srcv1 = '0; rf_srcv2 = '0;
    alu_r = '0; alu_bubble = 1'b1; ex_rd = '0; ex_load = 1'b0;
    mem_r = '0; mem_bubble = 1'b1; mem_rd = '0; wb_r = '0; wb_we = 1'b0; wb_dst = '0;
    #1 chk("rst_stall", id_stall, 1'b0);
    step(); step();
    chk("rst_bubble", id_bubble, 1'b1);
    chk("rst_pc", id_pc, 64'h200);
    chk("rst_instr", id_instr, 64'h13);
    chk("rst_opA", opA, 64'h0);
    chk("rst_opB", opB, 64'h0);
    rstn = 1'b1; ex_stall = 1'b0;

    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].instr, tbl[i].pc, tbl[i].rv1, tbl[i].rv2);
      #1 chk($sformatf("v%0d_stall", i), id_stall, 1'b0);
      step();
      chk($sformatf("v%0d_bubble", i), id_bubble, 1'b0);
      chk($sformatf("v%0d_pc", i), id_pc, tbl[i].pc);
      chk($sformatf("v%0d_instr", i), id_instr, {32'h0, tbl[i].instr});
      chk($sformatf("v%0d_opA", i), opA, tbl[i].exp_a);
      chk($sformatf("v%0d_opB", i), opB, tbl[i].exp_b);
      if_bubble = 1'b1;
      step();
      chk($sformatf("v%0d_gap", i), id_bubble, 1'b1);
    end

    // RAW on the instruction in ID: one bubble, then forward from alu_r
    fetch(32'hFFD00293, 64'h2000, 64'h0, 64'h0);
    step();
    fetch(32'h006281B3, 64'h2004, 64'hDEAD, 64'h22);
    #1 chk("raw_stall", id_stall, 1'b1);
    chk("raw_src1", rf_src1, 5'd5);
    chk("raw_src2", rf_src2, 5'd6);
    step();
    chk("raw_bubble", id_bubble, 1'b1);
    chk("raw_hold", id_instr, 64'hFFD00293);
    alu_bubble = 1'b0; ex_rd = 5'd5; alu_r = 64'd7;
    #1 chk("raw_release", id_stall, 1'b0);
    step();
    chk("raw_opA", opA, 64'd7);
    chk("raw_opB", opB, 64'h22);
    chk("raw_cap", id_bubble, 1'b0);
    alu_bubble = 1'b1; if_bubble = 1'b1;
    step();

    // load-use: stall while the load is in ALU, then take mem_r
    fetch(32'h006201B3, 64'h2100, 64'hBAD, 64'h22);
    alu_bubble = 1'b0; ex_load = 1'b1; ex_rd = 5'd4; alu_r = 64'h1234;
    for (int c = 0; c < 2; c++) begin
      #1 chk("lu_stall", id_stall, 1'b1);
      step();
      chk("lu_bubble", id_bubble, 1'b1);
    end
    alu_bubble = 1'b1; ex_load = 1'b0; mem_bubble = 1'b0; mem_rd = 5'd4; mem_r = 64'h55;
    #1 chk("lu_release", id_stall, 1'b0);
    step();
    chk("lu_opA", opA, 64'h55);
    chk("lu_opB", opB, 64'h22);

    // forwarding priority alu > mem > wb > rf on x4 (add x7,x4,x4)
    fetch(32'h004203B3, 64'h2200, 64'hD4, 64'hE5);
    alu_bubble = 1'b0; ex_rd = 5'd4; alu_r = 64'hA1;
    mem_r = 64'hB2; wb_we = 1'b1; wb_dst = 5'd4; wb_r = 64'hC3;
    step();
    chk("pri_alu_A", opA, 64'hA1);
    chk("pri_alu_B", opB, 64'hA1);
    alu_bubble = 1'b1;
    step();
    chk("pri_mem", opA, 64'hB2);
    mem_bubble = 1'b1;
    step();
    chk("pri_wb", opB, 64'hC3);
    wb_we = 1'b0;
    step();
    chk("pri_rf_A", opA, 64'hD4);
    chk("pri_rf_B", opB, 64'hE5);

    // x0 reads are zero even when every forward path targets x0
    fetch(32'h000001B3, 64'h2300, 64'h11, 64'h22);
    alu_bubble = 1'b0; ex_rd = 5'd0; alu_r = 64'h99;
    wb_we = 1'b1; wb_dst = 5'd0; wb_r = 64'hFF;
    #1 chk("x0_stall", id_stall, 1'b0);
    step();
    chk("x0_opA", opA, 64'h0);
    chk("x0_opB", opB, 64'h0);
    alu_bubble = 1'b1; wb_we = 1'b0;

    // flush wins over ex_stall
    fetch(32'hFFD00293, 64'h2400, 64'h0, 64'h0);
    ex_stall = 1'b1; pipe_flush = 1'b1;
    step();
    chk("flush_bubble", id_bubble, 1'b1);
    chk("flush_hold", id_instr, 64'h000001B3);
    ex_stall = 1'b0; pipe_flush = 1'b0;

    // ex_stall freezes everything for 3 cycles
    fetch(32'h3008E0F3, 64'h3000, 64'h0, 64'h0);
    step();
    chk("csri_opB", opB, 64'd17);
    fetch(32'h006281B3, 64'h3004, 64'h1, 64'h2);
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("frz_stall", id_stall, 1'b1);
      step();
      chk("frz_pc", id_pc, 64'h3000);
      chk("frz_instr", id_instr, 64'h3008E0F3);
      chk("frz_bubble", id_bubble, 1'b0);
      chk("frz_opA", opA, 64'h0);
      chk("frz_opB", opB, 64'd17);
    end
    ex_stall = 1'b0;
    step();
    chk("unfrz_pc", id_pc, 64'h3004);
    chk("unfrz_opA", opA, 64'h1);
    chk("unfrz_opB", opB, 64'h2);

    // empty fetch slot never raises a hazard (add x4,x3,x3 behind add x3)
    fetch(32'h000001B3, 64'h3100, 64'h0, 64'h0);
    step();
    fetch(32'h00318233, 64'h3104, 64'h0, 64'h0);
    if_bubble = 1'b1;
    #1 chk("ifb_stall", id_stall, 1'b0);
    step();
    chk("ifb_bubble", id_bubble, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
